// File: rtl/core_pkg.sv
// Shared pipeline definitions for the 5-stage RISC-V core: the decode control
// word, its bubble value and the ALU operation class encodings.
package core_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] RegDst;
    alu_op_e              ALUOp;
    logic                 ALUSrc;
    logic                 RegWrite;
    logic                 MemToReg;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 Branch;
  } ctrl_t;

  localparam ctrl_t       CTRL_NOP = '0;
  localparam int unsigned CTRL_W   = $bits(ctrl_t);

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, enable, and a
// synchronous clear that takes priority over the enable.
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   q_o <= '0;
    else if (clr_i) q_o <= '0;
    else if (en_i)  q_o <= d_i;
  end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures the decode control word and operands,
// with stall (hold), flush (bubble), valid tracking and a saturating bubble count.
module id_ex_pipeline_register
  import core_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned BUBBLE_CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [REG_ADDR_W-1:0]   RegDst_i,
  input  logic [1:0]              ALUOp_i,
  input  logic                    ALUSrc_i,
  input  logic                    RegWrite_i,
  input  logic                    MemToReg_i,
  input  logic                    MemRead_i,
  input  logic                    MemWrite_i,
  input  logic                    Branch_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic [XLEN-1:0]         imm_i,
  input  logic [REG_ADDR_W-1:0]   rs1_addr_i,
  input  logic [REG_ADDR_W-1:0]   rs2_addr_i,
  input  logic [3:0]              funct_i,
  output logic [REG_ADDR_W-1:0]   RegDst_o,
  output logic [1:0]              ALUOp_o,
  output logic                    ALUSrc_o,
  output logic                    RegWrite_o,
  output logic                    MemToReg_o,
  output logic                    MemRead_o,
  output logic                    MemWrite_o,
  output logic                    Branch_o,
  output logic [XLEN-1:0]         pc_o,
  output logic [XLEN-1:0]         rs1_data_o,
  output logic [XLEN-1:0]         rs2_data_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [REG_ADDR_W-1:0]   rs1_addr_o,
  output logic [REG_ADDR_W-1:0]   rs2_addr_o,
  output logic [3:0]              funct_o,
  output logic                    valid_o,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt_o
);

  localparam int unsigned DATA_W = 4 * XLEN + 2 * REG_ADDR_W + 4;

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_q;
  logic [CTRL_W:0]   ctrl_word_q;
  logic [DATA_W-1:0] data_q;
  logic              load;
  logic              bubble_evt;

  assign load       = !stall_i && !flush_i;
  assign bubble_evt = flush_i || (load && !valid_i);

  // An invalid instruction carries no side effects into EX.
  always_comb begin
    ctrl_in = CTRL_NOP;
    if (valid_i) begin
      ctrl_in.RegDst   = RegDst_i;
      ctrl_in.ALUOp    = alu_op_e'(ALUOp_i);
      ctrl_in.ALUSrc   = ALUSrc_i;
      ctrl_in.RegWrite = RegWrite_i;
      ctrl_in.MemToReg = MemToReg_i;
      ctrl_in.MemRead  = MemRead_i;
      ctrl_in.MemWrite = MemWrite_i;
      ctrl_in.Branch   = Branch_i;
    end
  end

  pipe_reg #(.W(CTRL_W + 1)) u_ctrl_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (!stall_i),
    .clr_i   (flush_i),
    .d_i     ({valid_i, ctrl_in}),
    .q_o     (ctrl_word_q)
  );

  pipe_reg #(.W(DATA_W)) u_data_reg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (!stall_i),
    .clr_i   (flush_i),
    .d_i     ({pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, funct_i}),
    .q_o     (data_q)
  );

  assign valid_o    = ctrl_word_q[CTRL_W];
  assign ctrl_q     = ctrl_word_q[CTRL_W-1:0];
  assign RegDst_o   = ctrl_q.RegDst;
  assign ALUOp_o    = ctrl_q.ALUOp;
  assign ALUSrc_o   = ctrl_q.ALUSrc;
  assign RegWrite_o = ctrl_q.RegWrite;
  assign MemToReg_o = ctrl_q.MemToReg;
  assign MemRead_o  = ctrl_q.MemRead;
  assign MemWrite_o = ctrl_q.MemWrite;
  assign Branch_o   = ctrl_q.Branch;

  assign {pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, funct_o} = data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_o <= '0;
    end else if (bubble_evt && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + BUBBLE_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register: vector table for single-cycle
// behaviour plus hand sequences for saturation and asynchronous reset.
module tb_id_ex_pipeline_register;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 4 * XLEN + 2 * RA_W + 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush, valid;
  logic [RA_W-1:0]   RegDst_i, RegDst_o;
  logic [1:0]        ALUOp_i, ALUOp_o;
  logic              ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i;
  logic              ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o;
  logic [XLEN-1:0]   pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [XLEN-1:0]   pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [RA_W-1:0]   rs1_addr_i, rs2_addr_i, rs1_addr_o, rs2_addr_o;
  logic [3:0]        funct_i, funct_o;
  logic              valid_o;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_register #(
    .XLEN         (XLEN),
    .REG_ADDR_W   (RA_W),
    .BUBBLE_CNT_W (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .stall_i      (stall),
    .flush_i      (flush),
    .valid_i      (valid),
    .RegDst_i     (RegDst_i),
    .ALUOp_i      (ALUOp_i),
    .ALUSrc_i     (ALUSrc_i),
    .RegWrite_i   (RegWrite_i),
    .MemToReg_i   (MemToReg_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .Branch_i     (Branch_i),
    .pc_i         (pc_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .imm_i        (imm_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .funct_i      (funct_i),
    .RegDst_o     (RegDst_o),
    .ALUOp_o      (ALUOp_o),
    .ALUSrc_o     (ALUSrc_o),
    .RegWrite_o   (RegWrite_o),
    .MemToReg_o   (MemToReg_o),
    .MemRead_o    (MemRead_o),
    .MemWrite_o   (MemWrite_o),
    .Branch_o     (Branch_o),
    .pc_o         (pc_o),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o),
    .imm_o        (imm_o),
    .rs1_addr_o   (rs1_addr_o),
    .rs2_addr_o   (rs2_addr_o),
    .funct_o      (funct_o),
    .valid_o      (valid_o),
    .bubble_cnt_o (bubble_cnt)
  );

  // Control word layout: {RegDst[4:0], ALUOp[1:0], ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch}
  typedef struct {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [12:0] ctrl;
    logic [31:0] pc;
    logic        exp_valid;
    logic [12:0] exp_ctrl;
    logic [31:0] exp_pc;
    logic        exp_dzero;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [DATA_W-1:0] data_of(input logic [31:0] p);
    logic [31:0] a, b, c;
    logic [4:0]  r1, r2;
    a  = p + 32'd1;
    b  = p + 32'd2;
    c  = p + 32'd3;
    r1 = p[4:0] + 5'd1;
    r2 = p[4:0] + 5'd2;
    return {p, a, b, c, r1, r2, p[3:0] ^ 4'h5};
  endfunction

  function automatic logic [12:0] ctrl_out();
    return {RegDst_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o};
  endfunction

  function automatic logic [DATA_W-1:0] data_out();
    return {pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, funct_o};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic v, input logic [12:0] c, input logic [31:0] p);
    logic [DATA_W-1:0] d;
    d     = data_of(p);
    stall = s;
    flush = f;
    valid = v;
    {RegDst_i, ALUOp_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i} = c;
    {pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, funct_i} = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 13'h0710, 32'h100, 1'b1, 13'h0710, 32'h100, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 13'h0302, 32'h104, 1'b1, 13'h0710, 32'h100, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 13'h0302, 32'h104, 1'b1, 13'h0710, 32'h100, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 13'h0302, 32'h104, 1'b1, 13'h0710, 32'h100, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 13'h0302, 32'h104, 1'b1, 13'h0302, 32'h104, 1'b0, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 13'h0302, 32'h108, 1'b0, 13'h0000, 32'h000, 1'b1, 4'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 13'h0005, 32'h200, 1'b0, 13'h0000, 32'h200, 1'b0, 4'd2};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 13'h1FFF, 32'h204, 1'b0, 13'h0000, 32'h200, 1'b0, 4'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 13'h1FAD, 32'h300, 1'b1, 13'h1FAD, 32'h300, 1'b0, 4'd2};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 13'h1FAD, 32'h304, 1'b0, 13'h0000, 32'h000, 1'b1, 4'd3};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 13'h1FFF, 32'h400, 1'b1, 13'h1FFF, 32'h400, 1'b0, 4'd3};

    // Reset with every input driven high
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, '1, '1);
    {pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, funct_i} = '1;
    step();
    step();
    chk("reset_valid", DATA_W'(valid_o), '0);
    chk("reset_ctrl", DATA_W'(ctrl_out()), '0);
    chk("reset_data", data_out(), '0);
    chk("reset_cnt", DATA_W'(bubble_cnt), '0);

    drive(vecs[0].stall, vecs[0].flush, vecs[0].valid, vecs[0].ctrl, vecs[0].pc);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].ctrl, vecs[i].pc);
      step();
      chk($sformatf("v%0d_valid", i), DATA_W'(valid_o), DATA_W'(vecs[i].exp_valid));
      chk($sformatf("v%0d_ctrl", i), DATA_W'(ctrl_out()), DATA_W'(vecs[i].exp_ctrl));
      chk($sformatf("v%0d_data", i), data_out(),
          vecs[i].exp_dzero ? '0 : data_of(vecs[i].exp_pc));
      chk($sformatf("v%0d_cnt", i), DATA_W'(bubble_cnt), DATA_W'(vecs[i].exp_cnt));
    end

    // Saturation: counter is at 3, so 10 flushes reach 13 and 10 more pin it at 15
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 13'h1FFF, 32'h500);
      step();
    end
    chk("sat_mid_cnt", DATA_W'(bubble_cnt), DATA_W'(13));
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 13'h1FFF, 32'h500);
      step();
    end
    chk("sat_cnt", DATA_W'(bubble_cnt), DATA_W'(15));
    chk("sat_valid", DATA_W'(valid_o), '0);
    drive(1'b0, 1'b0, 1'b0, 13'h1FFF, 32'h600);
    step();
    chk("sat_invalid_cnt", DATA_W'(bubble_cnt), DATA_W'(15));
    chk("sat_invalid_ctrl", DATA_W'(ctrl_out()), '0);

    // Asynchronous reset between edges while a valid instruction is held
    drive(1'b0, 1'b0, 1'b1, 13'h0712, 32'h700);
    step();
    chk("pre_arst_valid", DATA_W'(valid_o), DATA_W'(1));
    chk("pre_arst_ctrl", DATA_W'(ctrl_out()), DATA_W'(13'h0712));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", DATA_W'(valid_o), '0);
    chk("arst_ctrl", DATA_W'(ctrl_out()), '0);
    chk("arst_data", data_out(), '0);
    chk("arst_cnt", DATA_W'(bubble_cnt), '0);
    step();
    chk("arst_hold_valid", DATA_W'(valid_o), '0);
    drive(1'b0, 1'b0, 1'b1, 13'h0A80, 32'h800);
    rst_n = 1'b1;
    step();
    chk("post_arst_valid", DATA_W'(valid_o), DATA_W'(1));
    chk("post_arst_ctrl", DATA_W'(ctrl_out()), DATA_W'(13'h0A80));
    chk("post_arst_data", data_out(), data_of(32'h800));
    chk("post_arst_cnt", DATA_W'(bubble_cnt), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
# id_ex_pipeline_register

ID/EX pipeline register of the 5-stage RISC-V core. It sits directly downstream of `MUX_Control` and captures the muxed decode control word together with the decode-stage operands, then presents them to the EX stage one cycle later. It supports pipeline hold (stall), bubble insertion (flush) and a valid bit. A saturating bubble counter gives performance visibility.

## Interface
Parameters:
- `XLEN`, 32, datapath width of PC, operands and immediate.
- `REG_ADDR_W`, 5, register-file address width.
- `BUBBLE_CNT_W`, 16, width of the bubble counter.

Ports:
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  hold the current contents (EX not ready to accept).
- `flush_i`  in  1  load a bubble (branch taken, or load-use hazard in EX).
- `valid_i`  in  1  the ID-stage instruction is valid.
- `RegDst_i`  in  REG_ADDR_W  destination register from `MUX_Control`.
- `ALUOp_i`  in  2  ALU operation class.
- `ALUSrc_i`, `RegWrite_i`, `MemToReg_i`, `MemRead_i`, `MemWrite_i`, `Branch_i`  in  1 each  control bits.
- `pc_i`, `rs1_data_i`, `rs2_data_i`, `imm_i`  in  XLEN each  decode operands.
- `rs1_addr_i`, `rs2_addr_i`  in  REG_ADDR_W each  source register indices, used for forwarding.
- `funct_i`  in  4  {instr[30], funct3}.
- Registered copies with `_o` suffix of every data and control input above, same widths.
- `valid_o`  out  1  the EX-stage slot holds a real instruction.
- `bubble_cnt_o`  out  BUBBLE_CNT_W  number of bubbles loaded since reset; saturates.

## Operation
Each cycle the block selects exactly one action, in priority order:
- **flush**: `flush_i=1`. Load a bubble: `valid_o=0`, and every control output is 0 (RegDst, ALUOp, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch). Data outputs are don't-care; they are loaded with 0.
- **hold**: `stall_i=1` and `flush_i=0`. All registers, including `valid_o`, keep their values.
- **load**: otherwise. Capture all inputs and set `valid_o=valid_i`. When `valid_i=0`, the control outputs are forced to 0 exactly as in the flush case, so no side effect can leak into EX.
- Flush and stall asserted together: flush wins.

Bubble counter:
- Increments by 1 on every flush cycle.
- Also increments on every load cycle with `valid_i=0`.
- Does not count hold cycles.
- Saturates at 2^BUBBLE_CNT_W−1 and never wraps.

Control outputs are never non-zero while `valid_o=0`. This is an invariant and must hold after reset, flush and invalid loads.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset: while `rst_n_i=0`, every output is 0, including `valid_o` and `bubble_cnt_o`. Reset takes effect immediately and does not wait for a clock edge.
- Reset mid-operation discards the in-flight instruction.
- First update after reset release is on the first rising edge with `rst_n_i=1`.
- No combinational path from any input to any output.
- `stall_i` and `flush_i` are sampled at the same edge as the data.

## Structure
- Shared package `core_pkg` holds:
  - `ctrl_t`: packed struct {RegDst, ALUOp, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch}.
  - `CTRL_NOP`: all-zero `ctrl_t` constant.
  - `ALUOP_*` encodings.
- `MUX_Control` and the later EX/MEM register reuse the same package.
- One generic sub-module, `pipe_reg`, is natural:
  - Parameterised width, with enable and synchronous clear; the clear has priority.
  - Instantiated once for the data bundle and once for {valid, ctrl_t}.
- The bubble counter lives in the top level.

## Test plan
- Reset: hold `rst_n_i=0` with all inputs driven to 1 → all outputs 0. Release, load `RegWrite_i=1`, `RegDst_i=5'd7`, `valid_i=1` → next cycle `RegWrite_o=1`, `RegDst_o=7`, `valid_o=1`.
- Stall: load `pc_i=0x100`, then assert `stall_i` for 3 cycles while driving `pc_i=0x104` → `pc_o` stays 0x100 and `bubble_cnt_o` is unchanged. Release → `pc_o=0x104`.
- Flush beats stall: with `MemWrite_o=1`, assert `flush_i=1` and `stall_i=1` together → next cycle `valid_o=0`, `MemWrite_o=0`, `bubble_cnt_o` +1.
- Invalid load: `valid_i=0` with `MemRead_i=1`, `Branch_i=1` → `valid_o=0`, all control outputs 0, `bubble_cnt_o` +1.
- Saturation: with `BUBBLE_CNT_W=4`, drive 20 consecutive flushes → `bubble_cnt_o` stops at 15.
- Async reset mid-stream: drop `rst_n_i` between clock edges while `valid_o=1` → outputs go to 0 before the next edge.
